sad_search_ctrl: RTL and testbench

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

---
 rtl/sad_pkg.sv | 25 ++
 rtl/abs.sv | 15 +
 rtl/sad_search_ctrl.sv | 132 +++++++++++++
 tb/tb_sad_search_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and width helpers for the SAD search controller.
package sad_pkg;

    // Search controller FSM states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccum   = 2'd1,
        StCompare = 2'd2,
        StDone    = 2'd3
    } sad_state_e;

    // Accumulator width: holds WIN_PIX * (2^PIX_W - 1) without overflow.
    function automatic int unsigned acc_width(input int unsigned pix_w,
                                              input int unsigned win_pix);
        return pix_w + $clog2(win_pix);
    endfunction

    // Candidate index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_cand);
        int unsigned w;
        w = $clog2(num_cand);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/abs.sv
// Unsigned absolute difference |a - b|, symmetric in its operands.
module abs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        y = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Sum-of-absolute-differences search: accumulates one SAD per candidate window
// and keeps the minimum and the index of the first candidate that reached it.
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int unsigned PIX_W    = 5,
    parameter int unsigned WIN_PIX  = 16,
    parameter int unsigned NUM_CAND = 8,
    localparam int unsigned ACC_W   = acc_width(PIX_W, WIN_PIX),
    localparam int unsigned IDX_W   = idx_width(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    output logic             pix_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
);

    localparam int unsigned      CNT_W     = $clog2(WIN_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(WIN_PIX - 1);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

    sad_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0] cand_cnt_q, cand_cnt_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [PIX_W-1:0] diff;

    abs #(
        .WIDTH (PIX_W)
    ) u_abs (
        .a (pix_a),
        .b (pix_b),
        .y (diff)
    );

    // Next-state logic; abort wins over beat acceptance and over the compare.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pix_cnt_d  = pix_cnt_q;
        cand_cnt_d = cand_cnt_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StAccum;
                    acc_d      = '0;
                    pix_cnt_d  = '0;
                    cand_cnt_d = '0;
                    best_sad_d = '1;
                    best_idx_d = '0;
                end
            end
            StAccum: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (pix_valid) begin
                    acc_d     = acc_q + ACC_W'(diff);
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = StCompare;
                    end
                end
            end
            StCompare: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Strict compare: on a tie the earlier candidate is kept.
                    if (acc_q < best_sad_q) begin
                        best_sad_d = acc_q;
                        best_idx_d = cand_cnt_q;
                    end
                    if (cand_cnt_q == LAST_CAND) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StAccum;
                        cand_cnt_d = cand_cnt_q + IDX_W'(1);
                        acc_d      = '0;
                        pix_cnt_d  = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            pix_cnt_q  <= '0;
            cand_cnt_q <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pix_cnt_q  <= pix_cnt_d;
            cand_cnt_q <= cand_cnt_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

    // Status outputs decoded directly from the current state.
    always_comb begin
        pix_ready = (state_q == StAccum);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        best_sad  = best_sad_q;
        best_idx  = best_idx_q;
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed self-checking bench for sad_search_ctrl (PIX_W=5, WIN_PIX=4, NUM_CAND=3).
module tb_sad_search_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pix_valid;
    logic [4:0] pix_a;
    logic [4:0] pix_b;
    logic       pix_ready;
    logic       busy;
    logic       done;
    logic [6:0] best_sad;
    logic [1:0] best_idx;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] da [0:2];
    logic [4:0] db [0:2];

    sad_search_ctrl #(
        .PIX_W    (5),
        .WIN_PIX  (4),
        .NUM_CAND (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_a     (pix_a),
        .pix_b     (pix_b),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_idx  (best_idx)
    );

    always #5 clk = ~clk;

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [4:0] a0, input logic [4:0] b0,
                            input logic [4:0] a1, input logic [4:0] b1,
                            input logic [4:0] a2, input logic [4:0] b2);
        da[0] = a0; db[0] = b0;
        da[1] = a1; db[1] = b1;
        da[2] = a2; db[2] = b2;
    endtask

    task automatic start_search();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(pix_ready), 1);
        check("start_best_sad", 32'(best_sad), 127);
        check("start_best_idx", 32'(best_idx), 0);
    endtask

    // gap: 0 back-to-back, 1 alternate valid/idle, 2 random idle gaps.
    // Idle cycles carry (31,0) so any wrongly counted beat corrupts the SAD.
    task automatic feed_cand(input int c, input int gap, input int nbeats);
        int  ng;
        bit  accepted;
        logic rdy;
        for (int k = 0; k < nbeats; k++) begin
            ng = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < ng; g++) begin
                pix_valid = 1'b0;
                pix_a = 5'd31;
                pix_b = 5'd0;
                tick();
            end
            pix_valid = 1'b1;
            pix_a = da[c];
            pix_b = db[c];
            accepted = 1'b0;
            for (int w = 0; w < 20 && !accepted; w++) begin
                rdy = pix_ready;
                tick();
                if (rdy) accepted = 1'b1;
            end
            if (!accepted) begin
                n_checks++;
                n_errors++;
                $error("FAIL ready_timeout: observed pix_ready low for 20 cycles, expected 1");
            end
        end
        pix_valid = 1'b0;
    endtask

    // Called 1 unit after the final beat was accepted.
    // end_action: 0 nothing, 1 start in DONE cycle, 2 abort in DONE cycle.
    task automatic finish_check(input int exp_sad, input int exp_idx, input int end_action);
        check("compare_done", 32'(done), 0);
        check("compare_ready", 32'(pix_ready), 0);
        tick();
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("best_sad", 32'(best_sad), 32'(exp_sad));
        check("best_idx", 32'(best_idx), 32'(exp_idx));
        if (end_action == 1) start = 1'b1;
        if (end_action == 2) abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("post_done_low", 32'(done), 0);
        check("post_idle", 32'(busy), 0);
        tick();
        check("hold_idle", 32'(busy), 0);
        check("hold_sad", 32'(best_sad), 32'(exp_sad));
        check("hold_idx", 32'(best_idx), 32'(exp_idx));
    endtask

    task automatic run_search(input int gap, input int exp_sad, input int exp_idx,
                              input int end_action);
        start_search();
        for (int c = 0; c < 3; c++) feed_cand(c, gap, 4);
        finish_check(exp_sad, exp_idx, end_action);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        pix_valid = 1'b0;
        pix_a = '0;
        pix_b = '0;
        tick();
        tick();
        start = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(pix_ready), 0);
        check("rst_sad", 32'(best_sad), 0);
        check("rst_idx", 32'(best_idx), 0);
        rst = 1'b0;
        tick();

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'(busy), 0);

        // basic search: SADs 28, 0, 124
        set_data(5'd10, 5'd3, 5'd5, 5'd5, 5'd0, 5'd31);
        run_search(0, 0, 1, 0);

        // ties and operand symmetry: all SADs 8, start in DONE ignored
        set_data(5'd3, 5'd5, 5'd5, 5'd3, 5'd1, 5'd3);
        run_search(0, 8, 0, 1);

        // backpressure: toggled valid, then random gaps with abort in DONE
        set_data(5'd10, 5'd3, 5'd5, 5'd5, 5'd0, 5'd31);
        run_search(1, 0, 1, 0);
        run_search(2, 0, 1, 2);

        // maximum value
        set_data(5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
        run_search(0, 124, 0, 0);

        // start held during ACCUM is ignored
        set_data(5'd10, 5'd3, 5'd5, 5'd5, 5'd0, 5'd31);
        start_search();
        start = 1'b1;
        feed_cand(0, 0, 4);
        start = 1'b0;
        check("start_in_accum_busy", 32'(busy), 1);
        feed_cand(1, 0, 4);
        feed_cand(2, 0, 4);
        finish_check(0, 1, 0);

        // abort after 2 beats of cand1, together with a valid beat
        start_search();
        feed_cand(0, 0, 4);
        feed_cand(1, 0, 2);
        abort = 1'b1;
        pix_valid = 1'b1;
        pix_a = 5'd31;
        pix_b = 5'd0;
        tick();
        abort = 1'b0;
        pix_valid = 1'b0;
        check("abort_idle_next", 32'(busy), 0);
        check("abort_ready", 32'(pix_ready), 0);
        check("abort_no_done", 32'(done), 0);
        tick();
        check("abort_no_done_later", 32'(done), 0);
        run_search(0, 0, 1, 0);

        // reset mid-cand2
        start_search();
        feed_cand(0, 0, 4);
        feed_cand(1, 0, 4);
        feed_cand(2, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sad", 32'(best_sad), 0);
        check("midrst_idx", 32'(best_idx), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_ready", 32'(pix_ready), 0);
        tick();
        check("midrst_stay_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
